// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_queue
//  Brief    : Fetch buffer after the PC register. Issues I-mem requests,
//             queues returned words and hands them to decode, drops flushed work.
//  Revision : 1.0
// ============================================================================
module if_fetch_queue #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_i,
    output logic        pc_we_o,
    output logic        im_req_o,
    output logic [31:0] im_addr_o,
    input  logic        im_ack_i,
    input  logic [31:0] im_rdata_i,
    input  logic        flush_i,
    output logic        dec_valid_o,
    input  logic        dec_ready_i,
    output logic [31:0] dec_instr_o,
    output logic [31:0] dec_pc_o,
    output logic        dec_exc_o
);

    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_req_pc;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic [31:0] r_instr_mem [DEPTH];
    logic [31:0] r_pc_mem    [DEPTH];
    logic        r_exc_mem   [DEPTH];

    logic        w_outstanding;
    logic [AW:0] w_used;
    logic        w_space;
    logic        w_idle_go;
    logic        w_aligned;
    logic        w_issue;
    logic        w_mis;
    logic        w_ack_push;
    logic        w_push;
    logic        w_pop;
    logic        w_valid;

    // An outstanding request reserves a slot, so its ack always finds room.
    assign w_outstanding = (r_state != ST_IDLE);
    assign w_used        = r_count + {{AW{1'b0}}, w_outstanding};
    assign w_space       = (w_used < c_depth);
    assign w_aligned     = (pc_i[1:0] == 2'b00);
    assign w_idle_go     = !reset && (r_state == ST_IDLE) && !flush_i && w_space;
    assign w_issue       = w_idle_go && w_aligned;
    assign w_mis         = w_idle_go && !w_aligned;
    assign w_ack_push    = !reset && (r_state == ST_WAIT) && im_ack_i && !flush_i;
    assign w_push        = w_mis || w_ack_push;
    assign w_valid       = !reset && (r_count != '0);
    assign w_pop         = w_valid && dec_ready_i && !flush_i;

    assign pc_we_o     = !reset && (flush_i || w_issue || w_mis);
    assign im_req_o    = w_issue;
    assign im_addr_o   = w_issue ? pc_i : 32'h0;
    assign dec_valid_o = w_valid;
    assign dec_instr_o = w_valid ? r_instr_mem[r_rptr] : 32'h0;
    assign dec_pc_o    = w_valid ? r_pc_mem[r_rptr] : RESET_PC;
    assign dec_exc_o   = w_valid && r_exc_mem[r_rptr];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_issue) w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (im_ack_i)     w_state_nxt = ST_IDLE;
                else if (flush_i) w_state_nxt = ST_DROP;
            end
            ST_DROP: if (im_ack_i) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_req_pc <= 32'h0;
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_issue) r_req_pc <= pc_i;
            if (flush_i) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop)  r_rptr <= r_rptr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_mem[r_wptr] <= w_mis ? 32'h0 : im_rdata_i;
            r_pc_mem[r_wptr]    <= w_mis ? pc_i : r_req_pc;
            r_exc_mem[r_wptr]   <= w_mis;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// Testbench for if_fetch_queue: random fetch/flush/ready traffic checked by a
// queue-based reference model and a decoupled decode-side monitor.
module tb_if_fetch_queue;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_i = RESET_PC;
    logic        pc_we_o;
    logic        im_req_o;
    logic [31:0] im_addr_o;
    logic        im_ack_i = 1'b0;
    logic [31:0] im_rdata_i = 32'h0;
    logic        flush_i = 1'b0;
    logic        dec_valid_o;
    logic        dec_ready_i = 1'b0;
    logic [31:0] dec_instr_o;
    logic [31:0] dec_pc_o;
    logic        dec_exc_o;

    if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .pc_i(pc_i), .pc_we_o(pc_we_o),
        .im_req_o(im_req_o), .im_addr_o(im_addr_o), .im_ack_i(im_ack_i),
        .im_rdata_i(im_rdata_i), .flush_i(flush_i), .dec_valid_o(dec_valid_o),
        .dec_ready_i(dec_ready_i), .dec_instr_o(dec_instr_o), .dec_pc_o(dec_pc_o),
        .dec_exc_o(dec_exc_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } ent_t;

    ent_t        exp_q[$];
    int          vectors = 0;
    int          fails = 0;
    int          pops = 0;
    bit          inflight = 0;
    bit          dropped = 0;
    logic [31:0] inf_pc = 32'h0;
    logic [31:0] pc_next = RESET_PC;
    logic [31:0] flush_tgt = 32'h0;
    bit          mem_pending = 0;
    int          mem_cnt = 0;
    int          flush_pct = 0;
    int          ready_pct = 100;
    int          max_delay = 1;
    bit          rst_req = 1;
    bit          force_flush = 0;
    bit          force_ack = 0;
    logic [31:0] force_tgt = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as a queue plus one in-flight request record.
    always @(negedge clk) begin : model
        logic e_space, e_issue, e_mis, e_we;
        #1;
        if (reset) begin
            chk("rst_pc_we", 32'(pc_we_o), 32'h0);
            chk("rst_im_req", 32'(im_req_o), 32'h0);
            chk("rst_im_addr", im_addr_o, 32'h0);
            chk("rst_dec_valid", 32'(dec_valid_o), 32'h0);
            chk("rst_dec_instr", dec_instr_o, 32'h0);
            chk("rst_dec_pc", dec_pc_o, RESET_PC);
            chk("rst_dec_exc", 32'(dec_exc_o), 32'h0);
            exp_q.delete();
            inflight    = 0;
            dropped     = 0;
            mem_pending = 0;
            pc_next     = RESET_PC;
        end else begin
            e_space = (exp_q.size() + (inflight ? 1 : 0)) < DEPTH;
            e_issue = !flush_i && !inflight && e_space && (pc_i[1:0] == 2'b00);
            e_mis   = !flush_i && !inflight && e_space && (pc_i[1:0] != 2'b00);
            e_we    = flush_i || e_issue || e_mis;
            chk("pc_we", 32'(pc_we_o), 32'(e_we));
            chk("im_req", 32'(im_req_o), 32'(e_issue));
            chk("im_addr", im_addr_o, e_issue ? pc_i : 32'h0);
            chk("dec_valid", 32'(dec_valid_o), 32'(exp_q.size() != 0));
            if (exp_q.size() == 0) begin
                chk("empty_dec_pc", dec_pc_o, RESET_PC);
                chk("empty_dec_instr", dec_instr_o, 32'h0);
                chk("empty_dec_exc", 32'(dec_exc_o), 32'h0);
            end
            if (inflight && im_ack_i) begin
                if (!dropped && !flush_i)
                    exp_q.push_back('{pc: inf_pc, instr: im_rdata_i, exc: 1'b0});
                inflight = 0;
            end else if (inflight && flush_i) begin
                dropped = 1;
            end
            if (flush_i) exp_q.delete();
            if (e_issue) begin
                inflight    = 1;
                dropped     = 0;
                inf_pc      = pc_i;
                mem_pending = 1;
                mem_cnt     = $urandom_range(1, max_delay);
            end
            if (e_mis) exp_q.push_back('{pc: pc_i, instr: 32'h0, exc: 1'b1});
            pc_next = !e_we ? pc_i : (flush_i ? flush_tgt : pc_i + 32'd4);
        end
    end

    always @(negedge clk) begin : monitor
        ent_t e;
        #2;
        if (!reset && dec_valid_o && dec_ready_i && !flush_i) begin
            if (exp_q.size() == 0) begin
                vectors++;
                fails++;
                $display("FAIL pop_empty: got dec_pc %h, expected no entry", dec_pc_o);
            end else begin
                e = exp_q.pop_front();
                chk("dec_pc", dec_pc_o, e.pc);
                chk("dec_instr", dec_instr_o, e.instr);
                chk("dec_exc", 32'(dec_exc_o), 32'(e.exc));
                pops++;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
        reset      = rst_req;
        pc_i       = pc_next;
        im_ack_i   = 1'b0;
        im_rdata_i = $urandom;
        if (force_ack) begin
            im_ack_i  = 1'b1;
            force_ack = 0;
        end else if (mem_pending) begin
            mem_cnt--;
            if (mem_cnt <= 0) begin
                im_ack_i    = 1'b1;
                mem_pending = 0;
            end
        end
        if (reset) begin
            flush_i = 1'b0;
        end else if (force_flush) begin
            flush_i     = 1'b1;
            flush_tgt   = force_tgt;
            force_flush = 0;
        end else begin
            flush_i   = ($urandom_range(0, 99) < flush_pct);
            flush_tgt = 32'h3000 + 32'($urandom_range(0, 1023) << 2);
            if ($urandom_range(0, 5) == 0) flush_tgt = flush_tgt | 32'($urandom_range(1, 3));
        end
        dec_ready_i = ($urandom_range(0, 99) < ready_pct);
    endtask

    task automatic wait_inflight();
        for (int i = 0; i < 20; i++) begin
            if (inflight) return;
            cycle();
        end
        vectors++;
        fails++;
        $display("FAIL wait_inflight: got no request in 20 cycles, expected one");
    endtask

    initial begin
        rst_req = 1;
        repeat (3) cycle();
        rst_req = 0;
        repeat (30) cycle();
        // Decode stalled: only DEPTH fetches may complete, then resume.
        ready_pct = 0;
        repeat (20) cycle();
        ready_pct = 100;
        repeat (20) cycle();
        // Redirect while a fetch is outstanding.
        max_delay = 4;
        wait_inflight();
        force_flush = 1;
        force_tgt   = 32'h3100;
        repeat (10) cycle();
        force_flush = 1;
        force_tgt   = 32'h3002;
        repeat (4) cycle();
        force_flush = 1;
        force_tgt   = 32'h3000;
        repeat (6) cycle();
        flush_pct = 10;
        ready_pct = 70;
        repeat (1500) cycle();
        // Reset while waiting for an ack, then a stray ack.
        flush_pct = 0;
        ready_pct = 100;
        wait_inflight();
        rst_req = 1;
        repeat (2) cycle();
        rst_req   = 0;
        force_ack = 1;
        repeat (10) cycle();
        flush_pct = 12;
        ready_pct = 60;
        max_delay = 3;
        repeat (800) cycle();
        flush_pct = 0;
        ready_pct = 100;
        repeat (20) cycle();
        chk("progress", 32'(pops > 100), 32'h1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Fetch-side buffer directly downstream of the PC register in the P6 pipeline.
- Issues instruction-memory requests at the current PC and drives the PC register's write enable, so the PC advances only when a fetch is actually launched.
- Captures returned words into a small FIFO and presents them to decode through a valid/ready handshake.
- Handles redirect flushes, including discarding in-flight responses.

Parameters:
- DEPTH, 2, FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_3000, value driven on dec_pc_o when the FIFO is empty.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pc_i  in  32  current PC register output
- pc_we_o  out  1  write enable to the PC register; PC loads npc on the next edge
- im_req_o  out  1  one-cycle fetch request pulse
- im_addr_o  out  32  fetch address, equal to pc_i when im_req_o=1, else 0
- im_ack_i  in  1  response valid; arrives at least 1 cycle after the request
- im_rdata_i  in  32  instruction word, valid with im_ack_i
- flush_i  in  1  redirect (branch/jump/exception); the npc mux supplies the target
- dec_valid_o  out  1  head entry valid
- dec_ready_i  in  1  decode accepts the head entry
- dec_instr_o  out  32  head instruction
- dec_pc_o  out  32  head PC
- dec_exc_o  out  1  head entry is a misaligned-fetch exception (AdEL)

Behaviour:
- Reset state: FSM=IDLE, FIFO empty, outstanding=0.
- Outputs during reset and on the first edge after reset: pc_we_o=0, im_req_o=0, im_addr_o=0, dec_valid_o=0, dec_instr_o=0, dec_pc_o=RESET_PC, dec_exc_o=0.
- Space check: space = (count + outstanding) < DEPTH. outstanding is 1 in WAIT and DROP, else 0. This accounting guarantees an ack never finds the FIFO full.

FSM (IDLE, WAIT, DROP):
- IDLE, !flush_i, space, pc_i[1:0]==0:
  - im_req_o=1, im_addr_o=pc_i, pc_we_o=1.
  - Latch req_pc=pc_i. Next state WAIT.
- IDLE, !flush_i, space, pc_i[1:0]!=0:
  - No memory request.
  - Push {pc_i, 32'h0, exc=1} at this edge; pc_we_o=1. Stay IDLE.
- IDLE, no space, or flush_i: no request.
- WAIT, im_ack_i && !flush_i: push {req_pc, im_rdata_i, exc=0}; next state IDLE. No new request is issued in the ack cycle; this gives 1 bubble per fetch, which is accepted.
- WAIT, flush_i && im_ack_i: discard the data; next state IDLE.
- WAIT, flush_i && !im_ack_i: next state DROP.
- DROP: on im_ack_i discard the data and go to IDLE. A further flush_i in DROP keeps DROP.

Flush:
- pc_we_o=1 in any cycle with flush_i, so the PC loads the redirect target.
- The FIFO is cleared at that edge; a same-cycle pop or push is ignored.
- No request is issued in a flush cycle.

FIFO:
- Pop when dec_valid_o && dec_ready_i.
- Push and pop in the same cycle are both performed; count is unchanged.
- Read and write pointers are log2(DEPTH) bits and wrap naturally.
- dec_* outputs are combinational from the head entry. When empty, dec_instr_o=0, dec_pc_o=RESET_PC, dec_exc_o=0.
- Head data stays stable while dec_valid_o && !dec_ready_i.

Other rules:
- Reset mid-operation: state returns to IDLE. A later stray im_ack_i in IDLE is ignored and pushes nothing.
- Ordering: dec_pc_o sequence equals the issued PC sequence with flushed entries removed.
- pc_we_o is never asserted without either an issue, a misaligned push, or flush_i.

Test Plan:
- Reset, pc_i=0x3000, ack 1 cycle after each request, dec_ready_i=1 → requests at 0x3000, 0x3004, 0x3008 every 2 cycles. The decode stream shows the same PCs with their rdata. pc_we_o pulses once per request.
- dec_ready_i=0 with DEPTH=2 → exactly 2 fetches complete, then im_req_o and pc_we_o stay 0. Raising ready resumes fetching; order is preserved and there is no duplicate or lost PC.
- Request at 0x3010, flush_i asserted the next cycle, ack arriving 3 cycles later with 0xDEADBEEF → the word is dropped. pc_we_o=1 in the flush cycle. The next request goes to the new pc_i (e.g. 0x3100) only after the ack is consumed.
- Flush in the same cycle as an ack, with the FIFO holding 1 entry → FIFO empty and dec_valid_o=0 next cycle. The ack data never appears on decode.
- pc_i=0x3002 → no im_req_o. The entry appears with dec_exc_o=1, dec_pc_o=0x3002, dec_instr_o=0, and pc_we_o=1.
- Reset asserted while in WAIT, then a stray im_ack_i → FIFO stays empty and the FSM is in IDLE. The first post-reset request is at pc_i.
